// File: rtl/deserializer_frame.sv
// Serial byte stream to parallel frame deserializer.
// Collects NUM_WORDS bytes per frame into a 2-entry output FIFO.
module deserializer_frame #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 9,
  parameter int TIMEOUT   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_valid,
  input  logic                       i_ready,
  output logic [WIDTH*NUM_WORDS-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_drop,
  output logic                       o_timeout
);

  localparam int FW = WIDTH * NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);
  localparam logic [GW-1:0] GLIM = GW'(TIMEOUT - 1);

  typedef enum logic {
    s_IDLE,
    s_COLLECT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] bytes_q [NUM_WORDS];
  logic [IW-1:0]    idx;
  logic [GW-1:0]    gap;
  logic             push;
  logic [FW-1:0]    frame;

  logic [FW-1:0]    mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             full;
  logic             accept;

  // Byte collection FSM; the completed frame is pushed one edge later
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= s_IDLE;
      idx       <= '0;
      gap       <= '0;
      push      <= 1'b0;
      o_timeout <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) bytes_q[k] <= '0;
    end else begin
      push      <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        s_IDLE: begin
          gap <= '0;
          if (i_valid) begin
            bytes_q[0] <= i_data;
            idx        <= IW'(1);
            state      <= s_COLLECT;
          end
        end
        s_COLLECT: begin
          if (i_valid) begin
            bytes_q[idx] <= i_data;
            gap          <= '0;
            if (idx == LAST) begin
              idx   <= '0;
              push  <= 1'b1;
              state <= s_IDLE;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (gap == GLIM) begin
            gap       <= '0;
            idx       <= '0;
            o_timeout <= 1'b1;
            state     <= s_IDLE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        default: state <= s_IDLE;
      endcase
    end
  end

  // Pack the byte registers, byte 0 in the low lane
  always_comb begin
    frame = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      frame[WIDTH*k +: WIDTH] = bytes_q[k];
  end

  assign o_busy  = (state == s_COLLECT);
  assign o_valid = (count != 2'd0);
  assign o_data  = o_valid ? mem[rd_ptr] : '0;
  assign pop     = o_valid & i_ready;
  assign full    = (count == 2'd2);
  assign accept  = push & (~full | pop);

  // Two-entry frame FIFO; a push into a full FIFO without a pop is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      o_drop <= 1'b0;
    end else begin
      o_drop <= push & full & ~pop;
      if (pop) rd_ptr <= ~rd_ptr;
      if (accept) begin
        mem[wr_ptr] <= frame;
        wr_ptr      <= ~wr_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer_frame.sv
// Directed self-checking bench for deserializer_frame.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_deserializer_frame;

  localparam int FW = 72;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    din = '0;
  logic          vin = 1'b0;
  logic          rdy = 1'b0;
  logic [FW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_drop;
  logic          o_timeout;

  int checks = 0;
  int failures = 0;
  int n_to = 0;
  int n_drop = 0;

  deserializer_frame #(
    .WIDTH(8),
    .NUM_WORDS(9),
    .TIMEOUT(16)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data   (din),
    .i_valid  (vin),
    .i_ready  (rdy),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_drop   (o_drop),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_timeout === 1'b1) n_to = n_to + 1;
    if (o_drop === 1'b1) n_drop = n_drop + 1;
  end

  task automatic chk(input string tag, input logic [FW-1:0] obs,
                     input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    din = b;
    vin = 1'b1;
    tick();
    vin = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] s, input int g);
    for (int k = 0; k < 9; k++) begin
      send(s + 8'(k));
      if (k < 8) idle(g);
    end
  endtask

  function automatic logic [FW-1:0] seq(input logic [7:0] s);
    logic [FW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[8*k +: 8] = s + 8'(k);
    return r;
  endfunction

  initial begin
    int nb;
    int t0;
    int d0;

    // reset state
    #12;
    chk1("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, '0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_drop", o_drop, 1'b0);
    chk1("rst_timeout", o_timeout, 1'b0);
    tick();
    rst_n = 1'b1;

    // back-to-back frame 01..09
    rdy = 1'b1;
    nb = 0;
    for (int k = 1; k <= 9; k++) begin
      send(8'(k));
      if (o_busy) nb++;
    end
    chki("b2b_busy_cycles", nb, 8);
    chk1("b2b_valid_early", o_valid, 1'b0);
    tick();
    chk1("b2b_valid", o_valid, 1'b1);
    chk("b2b_data", o_data, 72'h090807060504030201);
    tick();
    chk1("b2b_popped", o_valid, 1'b0);

    // gapped stream, two frames held then drained in order
    rdy = 1'b0;
    t0 = n_to;
    send_frame(8'h10, 3);
    send_frame(8'h20, 3);
    tick();
    chki("gap_no_timeout", n_to - t0, 0);
    chk1("gap_valid", o_valid, 1'b1);
    chk("gap_f1", o_data, 72'h181716151413121110);
    rdy = 1'b1;
    tick();
    chk("gap_f2", o_data, 72'h282726252423222120);
    tick();
    chk1("gap_empty", o_valid, 1'b0);

    // three frames into a stalled consumer: third dropped
    rdy = 1'b0;
    d0 = n_drop;
    send_frame(8'h30, 0);
    send_frame(8'h40, 0);
    send_frame(8'h50, 0);
    chk1("drop_not_yet", o_drop, 1'b0);
    tick();
    chk1("drop_pulse", o_drop, 1'b1);
    chk("drop_head", o_data, seq(8'h30));
    tick();
    chk1("drop_end", o_drop, 1'b0);
    chki("drop_count", n_drop - d0, 1);
    rdy = 1'b1;
    tick();
    chk("drop_f2", o_data, seq(8'h40));
    tick();
    chk1("drop_empty", o_valid, 1'b0);

    // full buffer with a pop alongside the completing byte / the push
    rdy = 1'b0;
    d0 = n_drop;
    send_frame(8'h60, 0);
    send_frame(8'h70, 0);
    for (int k = 0; k < 8; k++) send(8'h80 + 8'(k));
    rdy = 1'b1;
    send(8'h88);
    rdy = 1'b0;
    tick();
    chk1("pp_no_drop", o_drop, 1'b0);
    chk("pp_head", o_data, seq(8'h70));
    send_frame(8'h90, 0);
    rdy = 1'b1;
    tick();
    chk1("pp2_no_drop", o_drop, 1'b0);
    chk("pp2_head", o_data, seq(8'h80));
    tick();
    chk("pp2_next", o_data, seq(8'h90));
    tick();
    chk1("pp2_empty", o_valid, 1'b0);
    chki("pp_drop_count", n_drop - d0, 0);

    // timeout after 4 bytes and 16 idle cycles
    t0 = n_to;
    for (int k = 0; k < 4; k++) send(8'h11 + 8'(k));
    idle(15);
    chk1("to_not_yet", o_timeout, 1'b0);
    chk1("to_busy", o_busy, 1'b1);
    tick();
    chk1("to_pulse", o_timeout, 1'b1);
    chk1("to_busy_fall", o_busy, 1'b0);
    tick();
    chk1("to_end", o_timeout, 1'b0);
    send_frame(8'hA0, 0);
    tick();
    chk1("to_clean_valid", o_valid, 1'b1);
    chk("to_clean_data", o_data, seq(8'hA0));
    tick();

    // byte landing on idle cycle 16 wins over the timeout
    for (int k = 0; k < 4; k++) send(8'hB0 + 8'(k));
    idle(15);
    send(8'hB4);
    chk1("late_no_timeout", o_timeout, 1'b0);
    chk1("late_busy", o_busy, 1'b1);
    for (int k = 5; k < 9; k++) send(8'hB0 + 8'(k));
    tick();
    chk("late_data", o_data, seq(8'hB0));
    chki("to_count", n_to - t0, 1);
    tick();

    // asynchronous reset mid-frame with a buffered frame
    rdy = 1'b0;
    send_frame(8'hC0, 0);
    for (int k = 0; k < 5; k++) send(8'hD0 + 8'(k));
    chk1("ar_pre_valid", o_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("ar_valid", o_valid, 1'b0);
    chk1("ar_busy", o_busy, 1'b0);
    chk("ar_data", o_data, '0);
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    send_frame(8'hE0, 0);
    tick();
    chk1("ar_post_valid", o_valid, 1'b1);
    chk("ar_post_data", o_data, seq(8'hE0));
    tick();
    chk1("ar_post_empty", o_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
